pipe_generator: RTL and testbench

Produces the three scrolling pipe positions consumed by the collision detector: pipe_xN/pipe_yN. pipe_xN is the pipe column; pipe_yN is the top of the 30-pixel gap.
Pipes scroll left one pixel per game tick, wrap off-screen and respawn with a pseudo-random gap height.
The block also runs the game state (idle/run/frozen) from the collided flag and keeps a pass score for the HUD.

---
 rtl/pipe_generator_if.sv | 27 ++
 rtl/pipe_generator.sv | 141 ++++++++++++++
 tb/tb_pipe_generator.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_generator_if.sv
// Pipe generator bus: game control inputs and the three pipe positions.
// master = generator side, slave = consumer/driver side.
interface pipe_generator_if;
  logic       start;
  logic       collided;
  logic [8:0] pipe_x1;
  logic [6:0] pipe_y1;
  logic [8:0] pipe_x2;
  logic [6:0] pipe_y2;
  logic [8:0] pipe_x3;
  logic [6:0] pipe_y3;
  logic       step;
  logic [7:0] score;
  logic       running;

  modport master (
    input  start, collided,
    output pipe_x1, pipe_y1, pipe_x2, pipe_y2,
    output pipe_x3, pipe_y3, step, score, running
  );

  modport slave (
    output start, collided,
    input  pipe_x1, pipe_y1, pipe_x2, pipe_y2,
    input  pipe_x3, pipe_y3, step, score, running
  );
endinterface

// File: rtl/pipe_generator.sv
// Scrolling pipe generator with idle/run/frozen game state and pass score.
// Optional PIPE_GEN_SPEEDUP_EN shortens the tick period as the score grows.
module pipe_generator #(
  parameter int unsigned TICK_DIV = 1000000,
  parameter int unsigned SPACING  = 64,
  parameter int unsigned Y_MIN    = 8,
  parameter int unsigned BOX_X    = 4
) (
  input logic              CLOCK_50,
  input logic              reset,
  pipe_generator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FROZEN
  } state_e;

  localparam logic [8:0] X_WRAP = 9'(3 * SPACING - 1);
  localparam logic [8:0] BOX    = 9'(BOX_X);
  localparam logic [2:0][8:0] X_RST = {
    9'(160 + 2 * SPACING), 9'(160 + SPACING), 9'd160
  };
  localparam logic [2:0][6:0] Y_RST = {7'd60, 7'd20, 7'd40};

  state_e          state_q, state_d;
  logic [2:0][8:0] x_q, x_d;
  logic [2:0][6:0] y_q, y_d;
  logic [23:0]     div_q, div_d;
  logic [7:0]      score_q, score_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic            step_q, step_d;
  logic            running_q, running_d;

  logic [23:0]     div_last;
  logic [6:0]      y_new;
  logic [1:0]      npass;
  logic [9:0]      sum;

`ifdef PIPE_GEN_SPEEDUP_EN
  logic [1:0] level;

  // Level saturates at 2 once score reaches 32.
  always_comb begin
    level    = (score_q[7:5] != 3'd0) ? 2'd2 : {1'b0, score_q[4]};
    div_last = (24'(TICK_DIV) >> level) - 24'd1;
  end
`else
  assign div_last = 24'(TICK_DIV - 1);
`endif

  assign y_new = 7'(Y_MIN) + {1'b0, lfsr_q[5:0]};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    div_d   = div_q;
    score_d = score_q;
    step_d  = 1'b0;
    npass   = 2'd0;
    sum     = 10'd0;
    lfsr_d  = {lfsr_q[6:0],
               lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          div_d   = 24'd0;
        end
      end
      RUN: begin
        // A collision wins over a tick due in the same cycle.
        if (bus.collided) begin
          state_d = FROZEN;
        end else if (div_q == div_last) begin
          div_d  = 24'd0;
          step_d = 1'b1;
          for (int i = 0; i < 3; i++) begin
            if (x_q[i] == BOX) npass = npass + 2'd1;
            if (x_q[i] == 9'd0) begin
              x_d[i] = X_WRAP;
              y_d[i] = y_new;
            end else begin
              x_d[i] = x_q[i] - 9'd1;
            end
          end
          sum     = {2'b00, score_q} + {8'd0, npass};
          score_d = (sum > 10'd255) ? 8'hFF : sum[7:0];
        end else begin
          div_d = div_q + 24'd1;
        end
      end
      FROZEN: begin
        if (bus.start) begin
          state_d = RUN;
          div_d   = 24'd0;
          x_d     = X_RST;
          y_d     = Y_RST;
          score_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= X_RST;
      y_q       <= Y_RST;
      div_q     <= 24'd0;
      score_q   <= 8'd0;
      lfsr_q    <= 8'hA5;
      step_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      div_q     <= div_d;
      score_q   <= score_d;
      lfsr_q    <= lfsr_d;
      step_q    <= step_d;
      running_q <= running_d;
    end
  end

  assign bus.pipe_x1 = x_q[0];
  assign bus.pipe_y1 = y_q[0];
  assign bus.pipe_x2 = x_q[1];
  assign bus.pipe_y2 = y_q[1];
  assign bus.pipe_x3 = x_q[2];
  assign bus.pipe_y3 = y_q[2];
  assign bus.step    = step_q;
  assign bus.score   = score_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_pipe_generator.sv
// Bench for pipe_generator: two instances (SPACING 64 and 4) against
// a cycle-level game model driven with directed and random stimulus.
module tb_pipe_generator;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic collided;

  always #5 clk = ~clk;

  pipe_generator_if b0 ();
  pipe_generator_if b1 ();

  assign b0.start    = start;
  assign b0.collided = collided;
  assign b1.start    = start;
  assign b1.collided = collided;

  pipe_generator #(.TICK_DIV(TD), .SPACING(64)) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (b0)
  );

  pipe_generator #(.TICK_DIV(TD), .SPACING(4)) dut_s (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (b1)
  );

  int ncmp = 0;
  int nfail = 0;

  // Model state; mode 0 idle, 1 run, 2 frozen.
  int        sp[2] = '{64, 4};
  int        mx[2][3];
  int        my[2][3];
  int        mscore[2];
  int        mdiv[2];
  int        mmode[2];
  bit        mstep[2];
  logic [7:0] mlf;

  function automatic int period(input int i);
`ifdef PIPE_GEN_SPEEDUP_EN
    int lv;
    lv = (mscore[i] >= 32) ? 2 : (mscore[i] >= 16) ? 1 : 0;
    return TD >> lv;
`else
    return TD + 0 * i;
`endif
  endfunction

  task automatic reload(input int i);
    for (int k = 0; k < 3; k++) mx[i][k] = 160 + k * sp[i];
    my[i][0] = 40;
    my[i][1] = 20;
    my[i][2] = 60;
    mscore[i] = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit c);
    logic [7:0] lf;
    int n;
    lf = mlf;
    for (int i = 0; i < 2; i++) begin
      mstep[i] = 1'b0;
      if (r) begin
        reload(i);
        mdiv[i] = 0;
        mmode[i] = 0;
      end else if (mmode[i] == 0) begin
        if (s) begin
          mmode[i] = 1;
          mdiv[i] = 0;
        end
      end else if (mmode[i] == 1) begin
        if (c) begin
          mmode[i] = 2;
        end else if (mdiv[i] == period(i) - 1) begin
          mdiv[i] = 0;
          mstep[i] = 1'b1;
          n = 0;
          for (int k = 0; k < 3; k++) begin
            if (mx[i][k] == 4) n++;
            if (mx[i][k] == 0) begin
              mx[i][k] = 3 * sp[i] - 1;
              my[i][k] = 8 + int'(lf[5:0]);
            end else begin
              mx[i][k]--;
            end
          end
          mscore[i] = (mscore[i] + n > 255) ? 255 : mscore[i] + n;
        end else begin
          mdiv[i]++;
        end
      end else if (s) begin
        reload(i);
        mdiv[i] = 0;
        mmode[i] = 1;
      end
    end
    mlf = r ? 8'hA5 : {mlf[6:0], ^(mlf & 8'hB8)};
  endtask

  function automatic logic [57:0] dut_vec(input int i);
    if (i == 0)
      return {b0.pipe_x1, b0.pipe_y1, b0.pipe_x2, b0.pipe_y2,
              b0.pipe_x3, b0.pipe_y3, b0.step, b0.score, b0.running};
    return {b1.pipe_x1, b1.pipe_y1, b1.pipe_x2, b1.pipe_y2,
            b1.pipe_x3, b1.pipe_y3, b1.step, b1.score, b1.running};
  endfunction

  function automatic logic [57:0] mdl_vec(input int i);
    return {9'(mx[i][0]), 7'(my[i][0]), 9'(mx[i][1]), 7'(my[i][1]),
            9'(mx[i][2]), 7'(my[i][2]), mstep[i], 8'(mscore[i]),
            mmode[i] == 1};
  endfunction

  task automatic cyc(input bit r, input bit s, input bit c);
    rst = r;
    start = s;
    collided = c;
    model_step(r, s, c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      ncmp++;
      if (dut_vec(i) !== mdl_vec(i)) begin
        nfail++;
        $display("FAIL reset inst%0d got=%h want=%h", i, dut_vec(i), mdl_vec(i));
      end
    end
    ncmp++;
    if ({b0.pipe_x1, b0.pipe_x2, b0.pipe_x3} !== {9'd160, 9'd224, 9'd288}) begin
      nfail++;
      $display("FAIL reset_x got=%0d/%0d/%0d want=160/224/288",
               b0.pipe_x1, b0.pipe_x2, b0.pipe_x3);
    end
    ncmp++;
    if ({b0.score, b0.step, b0.running} !== 10'd0) begin
      nfail++;
      $display("FAIL reset_ctl got=%0d/%b/%b want=0/0/0",
               b0.score, b0.step, b0.running);
    end
  endtask

  task automatic test_first_tick;
    int steps;
    steps = 0;
    cyc(0, 1, 0);
    for (int t = 0; t < 4; t++) begin
      cyc(0, 0, 0);
      if (b0.step === 1'b1) steps++;
      for (int i = 0; i < 2; i++) begin
        ncmp++;
        if (dut_vec(i) !== mdl_vec(i)) begin
          nfail++;
          $display("FAIL first_tick inst%0d got=%h want=%h",
                   i, dut_vec(i), mdl_vec(i));
        end
      end
    end
    ncmp++;
    if (steps != 1 || b0.step !== 1'b1) begin
      nfail++;
      $display("FAIL tick_period got=%0d steps want=1 on cycle 4", steps);
    end
    ncmp++;
    if ({b0.pipe_x1, b0.pipe_x2, b0.pipe_x3} !== {9'd159, 9'd223, 9'd287}) begin
      nfail++;
      $display("FAIL first_move got=%0d/%0d/%0d want=159/223/287",
               b0.pipe_x1, b0.pipe_x2, b0.pipe_x3);
    end
  endtask

  task automatic test_wrap_and_score;
    bit wrapped;
    bit scored;
    logic [7:0] lf_at;
    wrapped = 0;
    scored = 0;
    lf_at = 8'h00;
    for (int t = 0; t < 800 && !wrapped; t++) begin
      lf_at = mlf;
      cyc(0, 0, 0);
      for (int i = 0; i < 2; i++) begin
        ncmp++;
        if (dut_vec(i) !== mdl_vec(i)) begin
          nfail++;
          $display("FAIL wrap_run inst%0d got=%h want=%h",
                   i, dut_vec(i), mdl_vec(i));
        end
      end
      if (mstep[0] && mx[0][0] == 3 && !scored) begin
        scored = 1;
        ncmp++;
        if (b0.score !== 8'd1) begin
          nfail++;
          $display("FAIL first_pass got=%0d want=1", b0.score);
        end
      end
      if (mstep[0] && mx[0][0] == 191) wrapped = 1;
    end
    ncmp++;
    if (!wrapped || !scored) begin
      nfail++;
      $display("FAIL wrap_timeout got=%b/%b want=1/1", wrapped, scored);
    end
    ncmp++;
    if (b0.pipe_x1 !== 9'd191 || b0.pipe_y1 !== 7'(8 + int'(lf_at[5:0]))
        || b0.pipe_y1 < 7'd8 || b0.pipe_y1 > 7'd71) begin
      nfail++;
      $display("FAIL wrap_pipe1 got=%0d/%0d want=191/%0d",
               b0.pipe_x1, b0.pipe_y1, 8 + int'(lf_at[5:0]));
    end
    ncmp++;
    if ({b0.pipe_x2, b0.pipe_y2, b0.pipe_x3, b0.pipe_y3}
        !== {9'd63, 7'd20, 9'd127, 7'd60}) begin
      nfail++;
      $display("FAIL wrap_others got=%0d/%0d/%0d/%0d want=63/20/127/60",
               b0.pipe_x2, b0.pipe_y2, b0.pipe_x3, b0.pipe_y3);
    end
  endtask

  task automatic test_collide_on_tick;
    logic [57:0] held;
    int guard;
    guard = 0;
    while (!(mmode[0] == 1 && mdiv[0] == period(0) - 1) && guard < 50) begin
      cyc(0, 0, 0);
      guard++;
    end
    held = mdl_vec(0);
    cyc(0, 0, 1);
    ncmp++;
    if (b0.step !== 1'b0 || b0.running !== 1'b0
        || dut_vec(0) !== {held[57:10], 1'b0, held[8:1], 1'b0}) begin
      nfail++;
      $display("FAIL collide_tick got=%h want=%h", dut_vec(0),
               {held[57:10], 1'b0, held[8:1], 1'b0});
    end
    held = mdl_vec(0);
    for (int t = 0; t < 100; t++) begin
      cyc(0, 0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 2; i++) begin
        ncmp++;
        if (dut_vec(i) !== mdl_vec(i)) begin
          nfail++;
          $display("FAIL frozen inst%0d got=%h want=%h",
                   i, dut_vec(i), mdl_vec(i));
        end
      end
    end
    ncmp++;
    if (dut_vec(0) !== held) begin
      nfail++;
      $display("FAIL frozen_hold got=%h want=%h", dut_vec(0), held);
    end
  endtask

  task automatic test_restart;
    cyc(0, 1, 0);
    ncmp++;
    if ({b0.pipe_x1, b0.pipe_x2, b0.pipe_x3, b0.score, b0.running}
        !== {9'd160, 9'd224, 9'd288, 8'd0, 1'b1}) begin
      nfail++;
      $display("FAIL restart got=%0d/%0d/%0d/%0d/%b want=160/224/288/0/1",
               b0.pipe_x1, b0.pipe_x2, b0.pipe_x3, b0.score, b0.running);
    end
  endtask

  task automatic test_saturate;
    int extra;
    extra = 0;
    for (int t = 0; t < 6000 && extra < 48; t++) begin
      cyc(0, 0, 0);
      if (mscore[1] == 255) extra++;
      for (int i = 0; i < 2; i++) begin
        ncmp++;
        if (dut_vec(i) !== mdl_vec(i)) begin
          nfail++;
          $display("FAIL saturate_run inst%0d got=%h want=%h",
                   i, dut_vec(i), mdl_vec(i));
        end
      end
    end
    ncmp++;
    if (b1.score !== 8'd255 || extra < 48) begin
      nfail++;
      $display("FAIL saturate got=%0d want=255", b1.score);
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 1500; t++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 19) == 0));
      for (int i = 0; i < 2; i++) begin
        ncmp++;
        if (dut_vec(i) !== mdl_vec(i)) begin
          nfail++;
          $display("FAIL random inst%0d cyc%0d got=%h want=%h",
                   i, t, dut_vec(i), mdl_vec(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_run;
    cyc(0, 1, 0);
    for (int t = 0; t < 10; t++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    ncmp++;
    if ({b0.pipe_x1, b0.pipe_y1, b0.pipe_x2, b0.pipe_y2, b0.pipe_x3,
         b0.pipe_y3, b0.step, b0.score, b0.running}
        !== {9'd160, 7'd40, 9'd224, 7'd20, 9'd288, 7'd60, 1'b0, 8'd0, 1'b0}) begin
      nfail++;
      $display("FAIL reset_mid_run got=%h", dut_vec(0));
    end
    cyc(0, 0, 0);
    ncmp++;
    if (dut_vec(1) !== mdl_vec(1)) begin
      nfail++;
      $display("FAIL reset_idle inst1 got=%h want=%h", dut_vec(1), mdl_vec(1));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    collided = 1'b0;
    mlf = 8'hA5;
    test_reset;
    test_first_tick;
    test_wrap_and_score;
    test_collide_on_tick;
    test_restart;
    test_saturate;
    test_random;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
